// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port 512x32 memory
// (synchronous write, combinational read). One access is serialised at a
// time. Each access runs IDLE -> ACCESS -> DONE. Read data is returned in a
// per-port holding register, and completion is signalled by a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0    // 0: round-robin, 1: port 0 wins ties
) (
  input  logic              clk,
  input  logic              clr_n,
  // port 0: CPU datapath
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  // port 1: secondary master
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  // status and memory side
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;     // port that owns the access in flight
  logic              last;      // port granted most recently
  logic              winner;    // port that would be granted this cycle
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;

  // Pick the winning port from the current requests and arbitration history.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = 1'b0;
    grant  = 1'b0;
    if (state == IDLE) begin
      grant = req0 | req1;
      if (req0 && req1)
        winner = (FIXED_PRI != 0) ? 1'b0 : ~last;
      else
        winner = req1;
    end
  end

  // Next-state logic. ACCESS and DONE each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the access snapshot captured at the grant edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner   <= winner;
        last    <= winner;
        addr_q  <= winner ? addr1  : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
        we_q    <= winner ? we1    : we0;
      end
    end
  end

  // Ack pulses and read-data holding registers, updated at the ACCESS closing edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= (state == ACCESS) && !owner;
      ack1 <= (state == ACCESS) &&  owner;
      if (state == ACCESS && !we_q) begin
        if (owner) rdata1 <= mem_dataout;
        else       rdata0 <= mem_dataout;
      end
    end
  end

  // Memory drive and status come only from registers, never from req*.
  // The reset forces state to IDLE, so mem_write drops as soon as clr_n falls.
  assign mem_addr   = addr_q;
  assign mem_datain = wdata_q;
  assign mem_write  = we_q && (state == ACCESS);
  assign busy       = (state == ACCESS) || (state == DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. A round-robin instance sits on a
// behavioural 512x32 memory. A fixed-priority instance is exercised with
// writes only, and only its ack sequencing is checked.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;

  // round-robin instance
  logic        req0, we0, req1, we1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_write;
  logic [31:0] rdata0, rdata1, mem_datain, mem_dataout;
  logic [8:0]  mem_addr;

  // fixed-priority instance
  logic        f_req0, f_we0, f_req1, f_we1;
  logic [8:0]  f_addr0, f_addr1;
  logic [31:0] f_wdata0, f_wdata1;
  logic        f_ack0, f_ack1, f_busy, f_mem_write;
  logic [31:0] f_rdata0, f_rdata1, f_mem_datain;
  logic [31:0] f_mem_dataout = 32'h0;
  logic [8:0]  f_mem_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // behavioural memory: synchronous write, combinational read
  logic [31:0] mem [512];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_datain;
  assign mem_dataout = mem[mem_addr];

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(0)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_write(mem_write), .mem_dataout(mem_dataout)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .clr_n(clr_n),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1), .rdata1(f_rdata1),
    .busy(f_busy), .mem_addr(f_mem_addr), .mem_datain(f_mem_datain),
    .mem_write(f_mem_write), .mem_dataout(f_mem_dataout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one uncontended access on port p. The ack is expected two edges after the request is sampled.
  task automatic run_access(input logic p, input logic w, input logic [8:0] a,
                            input logic [31:0] d, input string tag);
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    tick();
    check({tag, "_mem_write"}, mem_write, w);
    tick();
    check({tag, "_ack"}, p ? ack1 : ack0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    f_req0 = 0; f_we0 = 0; f_addr0 = '0; f_wdata0 = '0;
    f_req1 = 0; f_we1 = 0; f_addr1 = '0; f_wdata1 = '0;

    // reset state
    #2;
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_datain", mem_datain, 0);
    tick();
    tick();
    clr_n = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 0);
    check("idle_ack0", ack0, 0);

    // port 0 write of 0xDEADBEEF to 0x005, cycle by cycle
    req0 = 1; we0 = 1; addr0 = 9'h005; wdata0 = 32'hDEADBEEF;
    tick();
    check("w5_mem_write", mem_write, 1);
    check("w5_busy", busy, 1);
    check("w5_mem_addr", mem_addr, 9'h005);
    check("w5_mem_datain", mem_datain, 32'hDEADBEEF);
    check("w5_ack_early", ack0, 0);
    tick();
    check("w5_ack0", ack0, 1);
    check("w5_ack1", ack1, 0);
    check("w5_mem_write_once", mem_write, 0);
    check("w5_busy_done", busy, 1);
    req0 = 0;
    tick();
    check("w5_ack_drop", ack0, 0);
    check("w5_busy_idle", busy, 0);
    check("w5_mem_word", mem[9'h005], 32'hDEADBEEF);

    // port 0 reads back 0x005; port 1 holding register untouched
    run_access(1'b0, 1'b0, 9'h005, 32'h0, "r5");
    check("r5_rdata0", rdata0, 32'hDEADBEEF);
    check("r5_rdata1", rdata1, 0);

    // preload: port 0 writes 0x1FF, port 1 writes 0x010 (port 1 is now last)
    run_access(1'b0, 1'b1, 9'h1FF, 32'h33334444, "w1ff");
    run_access(1'b1, 1'b1, 9'h010, 32'h11112222, "w010");
    check("wack_rdata0", rdata0, 32'hDEADBEEF);
    check("wack_rdata1", rdata1, 0);

    // round-robin contention: both held, grants go 0,1,0,1 with acks 3 cycles apart
    req0 = 1; we0 = 0; addr0 = 9'h010;
    req1 = 1; we1 = 0; addr1 = 9'h1FF;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("rr_ack0_e%0d", e), ack0, (e % 3 == 2) && ((e / 3) % 2 == 0));
      check($sformatf("rr_ack1_e%0d", e), ack1, (e % 3 == 2) && ((e / 3) % 2 == 1));
      if (e % 3 == 1)
        check($sformatf("rr_addr_e%0d", e), mem_addr, ((e / 3) % 2 == 0) ? 9'h010 : 9'h1FF);
      if (e == 2) check("rr_rdata0", rdata0, 32'h11112222);
      if (e == 5) check("rr_rdata1", rdata1, 32'h33334444);
    end
    req0 = 0;
    req1 = 0;
    tick();

    // input stability: the address changes during ACCESS but the access uses the granted one
    run_access(1'b0, 1'b1, 9'h020, 32'hA5A5A5A5, "w020");
    run_access(1'b0, 1'b1, 9'h021, 32'h5A5A5A5A, "w021");
    req0 = 1; we0 = 0; addr0 = 9'h020;
    tick();
    addr0 = 9'h021;
    #1;
    check("stab_mem_addr", mem_addr, 9'h020);
    tick();
    check("stab_ack0", ack0, 1);
    check("stab_rdata0", rdata0, 32'hA5A5A5A5);
    req0 = 0;
    tick();

    // reset during ACCESS of a write: mem_write falls at once, no ack, word unchanged
    run_access(1'b0, 1'b1, 9'h030, 32'h12345678, "w030");
    req0 = 1; we0 = 1; addr0 = 9'h030; wdata0 = 32'hCAFEF00D;
    tick();
    check("mrst_mem_write_pre", mem_write, 1);
    #1;
    clr_n = 1'b0;
    #1;
    check("mrst_mem_write", mem_write, 0);
    check("mrst_busy", busy, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_rdata0", rdata0, 0);
    req0 = 0;
    tick();
    check("mrst_ack0", ack0, 0);
    check("mrst_mem_word", mem[9'h030], 32'h12345678);
    #1;
    clr_n = 1'b1;
    tick();
    tick();
    check("mrst_idle_busy", busy, 0);
    check("mrst_idle_ack0", ack0, 0);
    run_access(1'b0, 1'b0, 9'h030, 32'h0, "r030");
    check("r030_rdata0", rdata0, 32'h12345678);

    // fixed priority: port 0 wins every tie; port 1 served only after req0 drops
    f_req0 = 1; f_we0 = 1; f_addr0 = 9'h001; f_wdata0 = 32'h00000001;
    f_req1 = 1; f_we1 = 1; f_addr1 = 9'h002; f_wdata1 = 32'h00000002;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check($sformatf("fp_ack0_e%0d", e), f_ack0, (e == 2) || (e == 5) || (e == 8));
      check($sformatf("fp_ack1_e%0d", e), f_ack1, e == 11);
      if (e == 8) f_req0 = 0;
    end
    f_req1 = 0;
    tick();
    check("fp_idle_busy", f_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the 512x32 single-port memory: synchronous write, combinational read, ports Datain/Address/Write/clk.
- Requester 0 is the CPU datapath (MAR/MDR path). Requester 1 is a secondary master, e.g. a DMA or program loader.
- The block serialises one access at a time onto the memory, returns read data in a per-port holding register and acknowledges each access with a one-cycle pulse.

Parameters:
- ADDR_W, 9, memory address width (512 words).
- DATA_W, 32, memory word width.
- FIXED_PRI, 0: 0 = round-robin between the two ports; 1 = port 0 always wins a tie.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 access request, held until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read); sampled with req0.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read-data holding register.
- req1, we1, addr1, wdata1, ack1, rdata1: same meanings for port 1.
- busy  out  1  high in ACCESS and DONE.
- mem_addr  out  ADDR_W  to memory Address.
- mem_datain  out  DATA_W  to memory Datain.
- mem_write  out  1  to memory Write.
- mem_dataout  in  DATA_W  from memory Dataout (combinational read).

Behaviour:
- Reset (clr_n=0, asynchronous, takes effect immediately):
  - state=IDLE; owner=0; last=1, so port 0 wins the first tie.
  - addr_q, wdata_q, we_q = 0.
  - mem_addr=0, mem_datain=0, mem_write=0, ack0=ack1=0, rdata0=rdata1=0, busy=0.
- Memory drive:
  - mem_addr=addr_q and mem_datain=wdata_q at all times.
  - mem_write = we_q AND (state==ACCESS). It is never high in any other state.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req with FIXED_PRI=0: grant the port != last. With FIXED_PRI=1: grant port 0.
  - On grant, at the edge:
    - owner <= winner.
    - addr_q, wdata_q, we_q <= the winner's inputs.
    - last <= winner.
    - Next state ACCESS.
- ACCESS: exactly one cycle, mem_write as above.
  - At the closing edge:
    - Write: memory captures wdata_q.
    - Read: rdata_owner <= mem_dataout. The other port's rdata is unchanged.
    - Next state DONE.
- DONE: exactly one cycle.
  - ack_owner=1 (registered, set on the ACCESS->DONE edge).
  - Next state IDLE unconditionally.
- Latency: req sampled at edge k; ACCESS during cycle k+1; ack high during cycle k+2; rdata valid from cycle k+2 and held until that port's next read completes.
- Throughput: one access per 3 cycles maximum.
- Write acks leave rdata unchanged.
- A requester drops req in the ack cycle. A req still high on return to IDLE counts as a new request.
- Request inputs are ignored outside IDLE. Changes to addr/wdata/we after the grant edge have no effect on the access in flight.
- Wrap-around: address is ADDR_W bits with no arithmetic, so no wrap logic. Address 511 is legal.
- Reset asserted in ACCESS drops mem_write asynchronously. The in-flight access is abandoned: no ack, and rdata cleared.
- No combinational path from req* to any output.

Test Plan:
- Reset check: clr_n=0 mid-run -> all outputs 0 immediately; after release with no req, state stays IDLE and busy=0.
- Port 0 write/read: req0, we0=1, addr0=0x005, wdata0=0xDEADBEEF.
  - Expected: mem_write high for exactly one cycle; ack0 in the 3rd cycle.
  - Then read addr 0x005: rdata0=0xDEADBEEF in the ack0 cycle; rdata1 stays 0.
- Round-robin contention (FIXED_PRI=0): req0 and req1 both held continuously, with reads of 0x010 and 0x1FF.
  - Expected: grants alternate 0,1,0,1; ack0 and ack1 3 cycles apart; no back-to-back grant of the same port.
- Fixed priority (FIXED_PRI=1): both requesting -> port 0 served every time; port 1 served only once req0 drops.
- Input stability: change addr0 from 0x020 to 0x021 during ACCESS -> the access uses 0x020; rdata0 = mem[0x020].
- Reset mid-write: clr_n low during ACCESS of a write to 0x030 -> mem_write falls the same instant, no ack, memory word unchanged.
